// File: rtl/tx_resp_packer_if.sv
// Response/FIFO-side bundle for tx_resp_packer.
//   rd_data / rd_vld    : register-file read byte and its 1-cycle strobe
//   alu_out / alu_vld   : ALU result and its 1-cycle strobe
//   fifo_full           : TX FIFO full flag
//   wr_data / w_inc     : byte and write enable toward the TX FIFO
//   busy                : packet in progress
//   drop_err            : 1-cycle pulse, a response was discarded
// The master modport is the response/FIFO environment; the slave modport is the packer.
interface tx_resp_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_vld;
    logic [ALU_WIDTH-1:0]  alu_out;
    logic                  alu_vld;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  w_inc;
    logic                  busy;
    logic                  drop_err;

    modport master (
        output rd_data, rd_vld, alu_out, alu_vld, fifo_full,
        input  wr_data, w_inc, busy, drop_err
    );

    modport slave (
        input  rd_data, rd_vld, alu_out, alu_vld, fifo_full,
        output wr_data, w_inc, busy, drop_err
    );
endinterface

// File: rtl/tx_resp_packer.sv
// Response packer between the system controller and the TX FIFO write port.
// Captures one response (8-bit register read or 16-bit ALU result), serializes
// it into FIFO bytes paced by fifo_full, optionally appends an XOR checksum
// byte, and pulses drop_err for any response it has to discard.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   bus   : tx_resp_packer_if.slave (strobes/data in, FIFO write side out)
module tx_resp_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_WIDTH   = 16,
    parameter bit CHECKSUM_EN = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    tx_resp_packer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_B0 = 2'd1,
        SEND_B1 = 2'd2,
        SEND_CS = 2'd3
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] b0_reg;
    logic [DATA_WIDTH-1:0] b1_reg;
    logic                  len2_reg;
    logic                  drop_reg;

    logic                  active;
    logic                  w_inc;
    logic [DATA_WIDTH-1:0] cs_byte;
    logic [DATA_WIDTH-1:0] sel_byte;

    assign active = (state_reg != IDLE);
    // A stalled SEND state simply keeps its byte on wr_data until the FIFO frees up.
    assign w_inc  = active & ~bus.fifo_full;

    // RD packets carry a single payload byte, so their checksum is that byte.
    assign cs_byte = len2_reg ? (b0_reg ^ b1_reg) : b0_reg;

    always_comb begin
        sel_byte = '0;
        case (state_reg)
            SEND_B0: sel_byte = b0_reg;
            SEND_B1: sel_byte = b1_reg;
            SEND_CS: sel_byte = cs_byte;
            default: sel_byte = '0;
        endcase
    end

    assign bus.wr_data  = sel_byte;
    assign bus.w_inc    = w_inc;
    assign bus.busy     = active;
    assign bus.drop_err = drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            b0_reg    <= '0;
            b1_reg    <= '0;
            len2_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            drop_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.alu_vld) begin
                        b0_reg    <= bus.alu_out[DATA_WIDTH-1:0];
                        b1_reg    <= bus.alu_out[ALU_WIDTH-1:DATA_WIDTH];
                        len2_reg  <= 1'b1;
                        state_reg <= SEND_B0;
                        // ALU has priority; a simultaneous RD response is lost.
                        drop_reg  <= bus.rd_vld;
                    end else if (bus.rd_vld) begin
                        b0_reg    <= bus.rd_data;
                        b1_reg    <= '0;
                        len2_reg  <= 1'b0;
                        state_reg <= SEND_B0;
                    end
                end
                SEND_B0: begin
                    if (w_inc) begin
                        if (len2_reg)
                            state_reg <= SEND_B1;
                        else if (CHECKSUM_EN)
                            state_reg <= SEND_CS;
                        else
                            state_reg <= IDLE;
                    end
                end
                SEND_B1: begin
                    if (w_inc)
                        state_reg <= CHECKSUM_EN ? SEND_CS : IDLE;
                end
                SEND_CS: begin
                    if (w_inc)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Any strobe seen while a packet is active is discarded, including
            // one on the very edge that writes the final byte.
            if (active && (bus.rd_vld || bus.alu_vld))
                drop_reg <= 1'b1;
        end
    end
endmodule
